regbank_scoreboard: RTL and testbench

//  Parametrised CPU register bank: two registered read ports, one write-back port with

---
 rtl/regbank_scoreboard_if.sv | 37 +++
 rtl/regbank_scoreboard.sv | 114 +++++++++++
 tb/tb_regbank_scoreboard.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regbank_scoreboard_if.sv
// Decode/write-back side bundle of the register bank: read ports, write-back,
// load-issue scoreboard controls and hazard/status outputs.
interface regbank_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
);
    localparam int ADDR_W = $clog2(NREGS);

    logic                get_regs;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic [DATA_W-1:0]   data_a;
    logic [DATA_W-1:0]   data_b;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic [1:0]          wb_mode;
    logic                wb_clr_pend;
    logic                pend_set;
    logic [ADDR_W-1:0]   pend_addr;
    logic                hazard_a;
    logic                hazard_b;
    logic [NREGS-1:0]    pend_mask;
    logic                err_dbl_pend;

    modport master (
        output get_regs, addr_a, addr_b, wb_valid, wb_addr, wb_data, wb_mode,
               wb_clr_pend, pend_set, pend_addr,
        input  data_a, data_b, hazard_a, hazard_b, pend_mask, err_dbl_pend
    );

    modport slave (
        input  get_regs, addr_a, addr_b, wb_valid, wb_addr, wb_data, wb_mode,
               wb_clr_pend, pend_set, pend_addr,
        output data_a, data_b, hazard_a, hazard_b, pend_mask, err_dbl_pend
    );
endinterface

// File: rtl/regbank_scoreboard.sv
// Register bank with two registered read ports, half-word write-back with
// same-cycle forwarding, and a per-register pending-load scoreboard.
module regbank_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regbank_scoreboard_if.slave  bus
);
    localparam int ADDR_W  = $clog2(NREGS);
    localparam int HALF_W  = DATA_W / 2;
    localparam int NPORTS  = 2;

    logic [NREGS-1:0][DATA_W-1:0]  regs;
    logic [NREGS-1:0]              pend;
    logic [NREGS-1:0]              pend_next;
    logic                          err_dbl;
    logic [DATA_W-1:0]             merged;
    logic                          wr_en;
    logic                          clr_en;
    logic                          set_en;
    logic                          dbl_hit;
    logic                          wb_is_zero;
    logic                          pend_is_zero;

    logic [NPORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NPORTS-1:0][DATA_W-1:0] rd_data;
    logic [NPORTS-1:0]             rd_hazard;

    assign wb_is_zero   = (ZERO_REG != 0) && (bus.wb_addr == '0);
    assign pend_is_zero = (ZERO_REG != 0) && (bus.pend_addr == '0);

    assign wr_en  = bus.wb_valid && (bus.wb_mode != 2'b11) && !wb_is_zero;
    assign clr_en = bus.wb_valid && bus.wb_clr_pend;
    assign set_en = bus.pend_set && !pend_is_zero;

    // Post-write word: the new half is always taken from the low half of wb_data.
    always_comb begin
        merged = regs[bus.wb_addr];
        case (bus.wb_mode)
            2'b00:   merged = bus.wb_data;
            2'b01:   merged[DATA_W-1:HALF_W] = bus.wb_data[HALF_W-1:0];
            2'b10:   merged[HALF_W-1:0]      = bus.wb_data[HALF_W-1:0];
            default: merged = regs[bus.wb_addr];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            regs <= '0;
        else if (wr_en)
            regs[bus.wb_addr] <= merged;
    end

    // Clear first, then set, so a new load issued on the returning register wins.
    always_comb begin
        pend_next = pend;
        if (clr_en)
            pend_next[bus.wb_addr] = 1'b0;
        if (set_en)
            pend_next[bus.pend_addr] = 1'b1;
    end

    assign dbl_hit = set_en && pend[bus.pend_addr] &&
                     !(clr_en && (bus.wb_addr == bus.pend_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= '0;
            err_dbl <= 1'b0;
        end else begin
            pend <= pend_next;
            if (dbl_hit)
                err_dbl <= 1'b1;
        end
    end

    assign rd_addr = {bus.addr_b, bus.addr_a};

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic rd_zero;
        logic rd_fwd;

        assign rd_zero = (ZERO_REG != 0) && (rd_addr[p] == '0);
        assign rd_fwd  = wr_en && (bus.wb_addr == rd_addr[p]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                rd_data[p] <= '0;
            else if (bus.get_regs) begin
                if (rd_zero)
                    rd_data[p] <= '0;
                else if (rd_fwd)
                    rd_data[p] <= merged;
                else
                    rd_data[p] <= regs[rd_addr[p]];
            end
        end

        // A load returning this cycle resolves the hazard; a same-cycle issue does not raise it.
        assign rd_hazard[p] = pend[rd_addr[p]] &&
                              !(clr_en && (bus.wb_addr == rd_addr[p])) &&
                              !rd_zero;
    end

    assign bus.data_a       = rd_data[0];
    assign bus.data_b       = rd_data[1];
    assign bus.hazard_a     = rd_hazard[0];
    assign bus.hazard_b     = rd_hazard[1];
    assign bus.pend_mask    = pend;
    assign bus.err_dbl_pend = err_dbl;
endmodule

// File: tb/tb_regbank_scoreboard.sv
// Directed bench: read data goes through an expectation queue checked by a
// monitor one cycle after each capture; status/hazard flags are checked inline.
module tb_regbank_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    cap_q = 1'b0;

    regbank_scoreboard_if #(.DATA_W(32), .NREGS(16)) bus ();

    regbank_scoreboard #(.DATA_W(32), .NREGS(16), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: a capture on one edge is observed at the following falling edge.
    always @(posedge clk) cap_q <= bus.get_regs && !reset;

    always @(negedge clk) begin
        if (cap_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_a"}, bus.data_a, e.a);
                check({e.name, "_b"}, bus.data_b, e.b);
            end
        end
    end

    task automatic idle();
        bus.get_regs    = 1'b0;
        bus.addr_a      = '0;
        bus.addr_b      = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.wb_mode     = 2'b00;
        bus.wb_clr_pend = 1'b0;
        bus.pend_set    = 1'b0;
        bus.pend_addr   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wb(input logic [3:0] a, input logic [31:0] d, input logic [1:0] m, input logic clr);
        bus.wb_valid    = 1'b1;
        bus.wb_addr     = a;
        bus.wb_data     = d;
        bus.wb_mode     = m;
        bus.wb_clr_pend = clr;
    endtask

    task automatic rd(input string name, input logic [3:0] aa, input logic [3:0] ab,
                      input logic [31:0] ea, input logic [31:0] eb);
        bus.get_regs = 1'b1;
        bus.addr_a   = aa;
        bus.addr_b   = ab;
        exp_q.push_back('{name, ea, eb});
    endtask

    task automatic pset(input logic [3:0] a);
        bus.pend_set  = 1'b1;
        bus.pend_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_a", bus.data_a, 32'h0);
        check("rst_data_b", bus.data_b, 32'h0);
        check("rst_pend", {16'h0, bus.pend_mask}, 32'h0);
        check("rst_err", {31'h0, bus.err_dbl_pend}, 32'h0);
        reset = 1'b0;
        tick();

        // Full-word write then read one cycle later.
        wb(4'd3, 32'hDEADBEEF, 2'b00, 1'b0);
        tick();
        rd("r3_full", 4'd3, 4'd0, 32'hDEADBEEF, 32'h0);
        tick();

        // Half-word modes with same-cycle forwarding.
        wb(4'd5, 32'h11112222, 2'b00, 1'b0);
        tick();
        wb(4'd5, 32'h0000ABCD, 2'b01, 1'b0);
        rd("fwd_hi", 4'd5, 4'd3, 32'hABCD2222, 32'hDEADBEEF);
        tick();
        wb(4'd5, 32'h00001234, 2'b10, 1'b0);
        rd("fwd_lo", 4'd5, 4'd5, 32'hABCD1234, 32'hABCD1234);
        tick();
        wb(4'd5, 32'hFFFFFFFF, 2'b11, 1'b0);
        rd("mode11_nowrite", 4'd5, 4'd3, 32'hABCD1234, 32'hDEADBEEF);
        tick();

        // Pending load on r7, then its return resolves the hazard.
        pset(4'd7);
        tick();
        check("pend_r7", {16'h0, bus.pend_mask}, 32'h0000_0080);
        bus.addr_a = 4'd3;
        bus.addr_b = 4'd7;
        #1;
        check("hazard_b_set", {31'h0, bus.hazard_b}, 32'h1);
        check("hazard_a_clear", {31'h0, bus.hazard_a}, 32'h0);
        tick();
        wb(4'd7, 32'hCAFEF00D, 2'b00, 1'b1);
        rd("r7_return", 4'd0, 4'd7, 32'h0, 32'hCAFEF00D);
        #1;
        check("hazard_b_resolved", {31'h0, bus.hazard_b}, 32'h0);
        tick();
        check("pend_r7_cleared", {16'h0, bus.pend_mask}, 32'h0);

        // Register zero ignores writes and pending loads.
        wb(4'd0, 32'hFFFFFFFF, 2'b00, 1'b0);
        pset(4'd0);
        rd("r0_fwd", 4'd0, 4'd3, 32'h0, 32'hDEADBEEF);
        tick();
        check("pend_r0", {16'h0, bus.pend_mask}, 32'h0);
        rd("r0_read", 4'd0, 4'd0, 32'h0, 32'h0);
        #1;
        check("hazard_r0", {31'h0, bus.hazard_a}, 32'h0);
        tick();

        // Same-cycle set and clear of r4: set wins, no error.
        pset(4'd4);
        tick();
        pset(4'd4);
        wb(4'd4, 32'h0, 2'b11, 1'b1);
        bus.addr_a = 4'd4;
        #1;
        check("hazard_r4_resolving", {31'h0, bus.hazard_a}, 32'h0);
        tick();
        check("pend_r4_setwins", {16'h0, bus.pend_mask}, 32'h0000_0010);
        check("err_after_setclr", {31'h0, bus.err_dbl_pend}, 32'h0);

        // Double issue on r2 raises the sticky error.
        pset(4'd2);
        tick();
        check("err_single_set", {31'h0, bus.err_dbl_pend}, 32'h0);
        pset(4'd2);
        tick();
        check("err_dbl", {31'h0, bus.err_dbl_pend}, 32'h1);
        check("pend_r2_r4", {16'h0, bus.pend_mask}, 32'h0000_0014);
        wb(4'd2, 32'h0, 2'b11, 1'b1);
        tick();
        check("err_sticky", {31'h0, bus.err_dbl_pend}, 32'h1);
        check("pend_r4_only", {16'h0, bus.pend_mask}, 32'h0000_0010);

        // Async reset mid-cycle with non-zero state.
        pset(4'd9);
        rd("pre_reset", 4'd3, 4'd5, 32'hDEADBEEF, 32'hABCD1234);
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("async_data_a", bus.data_a, 32'h0);
        check("async_data_b", bus.data_b, 32'h0);
        check("async_pend", {16'h0, bus.pend_mask}, 32'h0);
        check("async_err", {31'h0, bus.err_dbl_pend}, 32'h0);
        tick();
        reset = 1'b0;

        // Load returning after reset writes normally; its clear is a no-op.
        wb(4'd9, 32'h12345678, 2'b00, 1'b1);
        tick();
        check("late_return_pend", {16'h0, bus.pend_mask}, 32'h0);
        rd("late_return", 4'd9, 4'd5, 32'h12345678, 32'h0);
        tick();
        tick();
        tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
